// File: rtl/true_dual_port_ram.sv
`default_nettype none
// ============================================================================
// Module      : true_dual_port_ram
// Description : Parametrised true dual-port synchronous RAM on a single clock.
//               Two independent read/write ports (A, B). Reads are registered
//               with a one-cycle valid strobe. After reset, a hardware sweep
//               writes zero to every entry; port requests are ignored while
//               the sweep runs (busy=1).
//
//               Same-port read-during-write is selected by RD_MODE
//               (0 = read-first / old data, 1 = write-first / new data).
//               Cross-port accesses to one address in the same cycle:
//                 - both write : port A wins, port B write is dropped
//                 - write+read : the reader sees the old data
//
//               Optional feature macro: TDPRAM_COLLISION_DET_EN
//                 When defined, a registered 'collision' output pulses for
//                 one cycle after any RUN edge where both ports are enabled
//                 on the same address and at least one of them writes.
//
// Ports       : clk                 clock, rising edge
//               rst                 synchronous active-high reset
//               busy                high during reset / clear sweep
//               a_addr/a_din        port A address / write data
//               a_we/a_re           port A write / read enable
//               a_dout/a_valid      port A registered read data / valid
//               b_*                 as port A, for port B
//               collision           (macro build only) conflict pulse
//
// Revision    : 1.0 - initial release
// ============================================================================
module true_dual_port_ram #(
    parameter int WIDTH   = 8,
    parameter int ADDR_W  = 4,
    parameter int RD_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [WIDTH-1:0]  a_din,
    input  logic              a_we,
    input  logic              a_re,
    output logic [WIDTH-1:0]  a_dout,
    output logic              a_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [WIDTH-1:0]  b_din,
    input  logic              b_we,
    input  logic              b_re,
    output logic [WIDTH-1:0]  b_dout,
    output logic              b_valid
`ifdef TDPRAM_COLLISION_DET_EN
    ,
    output logic              collision
`endif
);

    localparam int         c_DEPTH = 2 ** ADDR_W;
    localparam logic [0:0] c_CLEAR = 1'b0;
    localparam logic [0:0] c_RUN   = 1'b1;

    // ------------------------------------------------------------------
    // Storage and control state
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  r_mem [c_DEPTH];
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_busy;
    logic [WIDTH-1:0]  r_a_dout;
    logic              r_a_valid;
    logic [WIDTH-1:0]  r_b_dout;
    logic              r_b_valid;

    logic              w_run;
    logic              w_clr_last;
    logic              w_clr_wr;
    logic              w_same_addr;
    logic              w_a_wr;
    logic              w_b_wr;
    logic              w_a_rd;
    logic              w_b_rd;
    logic [WIDTH-1:0]  w_a_rd_data;
    logic [WIDTH-1:0]  w_b_rd_data;

    // rst is folded into the enables so that no array write and no read
    // capture can happen on an edge where reset is asserted.
    assign w_run       = (r_state == c_RUN) && !rst;
    assign w_clr_wr    = (r_state == c_CLEAR) && !rst;
    assign w_clr_last  = (r_clr_cnt == {ADDR_W{1'b1}});
    assign w_same_addr = (a_addr == b_addr);

    // Port A has write priority; B's write to the same address is dropped.
    assign w_a_wr = w_run && a_we;
    assign w_b_wr = w_run && b_we && !(w_a_wr && w_same_addr);
    assign w_a_rd = w_run && a_re;
    assign w_b_rd = w_run && b_re;

    // ------------------------------------------------------------------
    // Read data selection. Only a port's own write can bypass the array;
    // the other port's write is never forwarded, which gives read-first
    // behaviour across ports in both modes.
    // ------------------------------------------------------------------
    generate
        if (RD_MODE == 1) begin : g_write_first
            assign w_a_rd_data = a_we ? a_din : r_mem[a_addr];
            assign w_b_rd_data = b_we ? b_din : r_mem[b_addr];
        end else begin : g_read_first
            assign w_a_rd_data = r_mem[a_addr];
            assign w_b_rd_data = r_mem[b_addr];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Clear sweep / run state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_CLEAR;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                c_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    // The edge that clears the last entry also opens the RAM.
                    if (w_clr_last) begin
                        r_state <= c_RUN;
                        r_busy  <= 1'b0;
                    end
                end
                c_RUN: begin
                    r_state <= c_RUN;
                end
                default: begin
                    r_state   <= c_CLEAR;
                    r_clr_cnt <= '0;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Array writes. The array itself carries no reset; it is zeroed by the
    // sweep. Sweep and port writes are mutually exclusive by state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_clr_wr) begin
            r_mem[r_clr_cnt] <= '0;
        end
        if (w_a_wr) begin
            r_mem[a_addr] <= a_din;
        end
        if (w_b_wr) begin
            r_mem[b_addr] <= b_din;
        end
    end

    // ------------------------------------------------------------------
    // Registered read ports; dout holds its value when no read is issued.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_dout  <= '0;
            r_a_valid <= 1'b0;
            r_b_dout  <= '0;
            r_b_valid <= 1'b0;
        end else begin
            r_a_valid <= w_a_rd;
            r_b_valid <= w_b_rd;
            if (w_a_rd) begin
                r_a_dout <= w_a_rd_data;
            end
            if (w_b_rd) begin
                r_b_dout <= w_b_rd_data;
            end
        end
    end

    assign busy    = r_busy;
    assign a_dout  = r_a_dout;
    assign a_valid = r_a_valid;
    assign b_dout  = r_b_dout;
    assign b_valid = r_b_valid;

`ifdef TDPRAM_COLLISION_DET_EN
    // ------------------------------------------------------------------
    // Collision detect: both ports active on one address with a write.
    // ------------------------------------------------------------------
    logic r_collision;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_collision <= 1'b0;
        end else begin
            r_collision <= w_run && (a_we || a_re) && (b_we || b_re) &&
                           w_same_addr && (a_we || b_we);
        end
    end

    assign collision = r_collision;
`endif

endmodule
`default_nettype wire
